// File: rtl/hub75e_bcm_scan_ctrl_if.sv
// Signal bundle between hub75e_bcm_scan_ctrl and its pixel RAM / HUB75E panel side.
interface hub75e_bcm_scan_ctrl_if #(
  parameter int AW = 12,
  parameter int PW = 3
);
  logic          enable;
  logic          swap_req;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [PW-1:0] plane;
  logic [4:0]    row_addr;
  logic          hub_ck;
  logic          hub_st;
  logic          hub_oe_n;
  logic          bank;
  logic          swap_ack;
  logic          frame_start;
  logic          busy;

  modport master (
    input  enable, swap_req,
    output ram_addr, ram_rd, plane, row_addr, hub_ck, hub_st, hub_oe_n,
           bank, swap_ack, frame_start, busy
  );

  modport slave (
    output enable, swap_req,
    input  ram_addr, ram_rd, plane, row_addr, hub_ck, hub_st, hub_oe_n,
           bank, swap_ack, frame_start, busy
  );
endinterface

// File: rtl/hub75e_bcm_scan_ctrl.sv
// HUB75E binary-code-modulation scan sequencer: rows x bitplanes, shift/latch/OE timing.
// Optional DOUBLE_BUFFER_EN macro enables front/back bank swapping at frame end.
module hub75e_bcm_scan_ctrl #(
  parameter int COLS    = 64,
  parameter int ROWS    = 32,
  parameter int BITS    = 5,
  parameter int BASE_OE = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  hub75e_bcm_scan_ctrl_if.master bus
);
  localparam int CW         = $clog2(COLS);
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW         = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int AW         = 1 + RW + CW;
  localparam int SHIFT_LAST = 2 * COLS;
  localparam int OE_MAX     = BASE_OE << (BITS - 1);
  localparam int TW_SH      = $clog2(SHIFT_LAST + 1);
  localparam int TW_OE      = $clog2(OE_MAX + 1);
  localparam int TW         = (TW_SH > TW_OE) ? TW_SH : TW_OE;

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, GUARD, DISPLAY} state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [RW-1:0]  row, row_nx;
  logic [PW-1:0]  plane_r, plane_nx;
  logic           bank_r, bank_nx;
  logic           swap_nx;
  logic [TW-1:0]  oe_len;

  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic           ram_rd_q, ram_rd_d;
  logic [4:0]     row_addr_q, row_addr_d;
  logic           hub_ck_q, hub_ck_d;
  logic           hub_st_q, hub_st_d;
  logic           oe_n_q, oe_n_d;
  logic           swap_q;
  logic           fs_q, fs_d;
  logic           busy_q, busy_d;

  assign oe_len = TW'(BASE_OE) << plane_r;

  // State, counters and all outputs registered together so outputs line up with state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      timer      <= '0;
      row        <= '0;
      plane_r    <= '0;
      bank_r     <= 1'b0;
      swap_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      row_addr_q <= '0;
      hub_ck_q   <= 1'b0;
      hub_st_q   <= 1'b0;
      oe_n_q     <= 1'b1;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      row        <= row_nx;
      plane_r    <= plane_nx;
      bank_r     <= bank_nx;
      swap_q     <= swap_nx;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      row_addr_q <= row_addr_d;
      hub_ck_q   <= hub_ck_d;
      hub_st_q   <= hub_st_d;
      oe_n_q     <= oe_n_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    row_nx   = row;
    plane_nx = plane_r;
    bank_nx  = bank_r;
    swap_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nx = SHIFT;
          timer_nx = '0;
          row_nx   = '0;
          plane_nx = '0;
        end
      end
      SHIFT: begin
        if (timer == TW'(SHIFT_LAST)) begin
          state_nx = LATCH;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      LATCH: state_nx = GUARD;
      GUARD: begin
        state_nx = DISPLAY;
        timer_nx = '0;
      end
      DISPLAY: begin
        if (timer == oe_len - 1'b1) begin
          timer_nx = '0;
          if (plane_r == PW'(BITS - 1)) begin
            plane_nx = '0;
            if (row == RW'(ROWS - 1)) begin
              row_nx = '0;
`ifdef DOUBLE_BUFFER_EN
              if (bus.swap_req) begin
                bank_nx = ~bank_r;
                swap_nx = 1'b1;
              end
`endif
            end else begin
              row_nx = row + 1'b1;
            end
          end else begin
            plane_nx = plane_r + 1'b1;
          end
          // Stopping discards the advanced position; a restart always begins a fresh frame.
          if (bus.enable) begin
            state_nx = SHIFT;
          end else begin
            state_nx = IDLE;
            row_nx   = '0;
            plane_nx = '0;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic shifting, fetch, bank_bit;

  always_comb begin
`ifdef DOUBLE_BUFFER_EN
    bank_bit   = bank_nx;
`else
    bank_bit   = 1'b0;
`endif
    shifting   = (state_nx == SHIFT);
    fetch      = shifting && (timer_nx < TW'(SHIFT_LAST));
    ram_addr_d = fetch ? {bank_bit, row_nx, timer_nx[CW:1]} : ram_addr_q;
    ram_rd_d   = fetch;
    // Column c is on the RAM bus at k=2c+1..2c+2; the clock edge lands mid-window.
    hub_ck_d   = shifting && (timer_nx != '0) && !timer_nx[0];
    hub_st_d   = (state_nx == LATCH);
    row_addr_d = (state_nx == LATCH) ? 5'(row_nx) : row_addr_q;
    oe_n_d     = (state_nx != DISPLAY);
    fs_d       = shifting && (timer_nx == '0) && (row_nx == '0) && (plane_nx == '0);
    busy_d     = (state_nx != IDLE);
  end

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.plane       = plane_r;
  assign bus.row_addr    = row_addr_q;
  assign bus.hub_ck      = hub_ck_q;
  assign bus.hub_st      = hub_st_q;
  assign bus.hub_oe_n    = oe_n_q;
  assign bus.bank        = bank_r;
  assign bus.swap_ack    = swap_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_hub75e_bcm_scan_ctrl.sv
// Directed bench for hub75e_bcm_scan_ctrl with COLS=4, ROWS=2, BITS=3, BASE_OE=2.
module tb_hub75e_bcm_scan_ctrl;
  localparam int AW = 4;
  localparam int PW = 2;
  localparam logic [18:0] RST_VEC = 19'h00010;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  hub75e_bcm_scan_ctrl_if #(.AW(AW), .PW(PW)) bus ();

  hub75e_bcm_scan_ctrl #(
    .COLS(4), .ROWS(2), .BITS(3), .BASE_OE(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.enable = 1'b0;
    bus.swap_req = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  function automatic logic [18:0] outs();
    return {bus.ram_addr, bus.ram_rd, bus.plane, bus.row_addr, bus.hub_ck, bus.hub_st,
            bus.hub_oe_n, bus.bank, bus.swap_ack, bus.frame_start, bus.busy};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    bus.enable = 1'b1;
    bus.swap_req = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_err++; $display("FAIL reset_held: got %h expected %h", outs(), RST_VEC);
    end
    bus.enable = 1'b0;
    bus.swap_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_err++; $display("FAIL idle_after_reset: got %h expected %h", outs(), RST_VEC);
    end
  endtask

  task automatic test_first_row();
    logic exp_ck;
    bus.enable = 1'b1;
    tick();
    n_cmp++;
    if (bus.frame_start !== 1'b1) begin
      n_err++; $display("FAIL first_frame_start: got %b expected 1", bus.frame_start);
    end
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      exp_ck = (k != 0) && (k % 2 == 0);
      n_cmp++;
      if (bus.hub_ck !== exp_ck) begin
        n_err++; $display("FAIL shift_ck k=%0d: got %b expected %b", k, bus.hub_ck, exp_ck);
      end
      n_cmp++;
      if (bus.ram_rd !== (k < 8)) begin
        n_err++; $display("FAIL shift_rd k=%0d: got %b expected %b", k, bus.ram_rd, (k < 8));
      end
      if (k < 8) begin
        n_cmp++;
        if (bus.ram_addr !== AW'(k / 2)) begin
          n_err++; $display("FAIL shift_addr k=%0d: got %0d expected %0d", k, bus.ram_addr, k / 2);
        end
      end
      n_cmp++;
      if (bus.hub_oe_n !== 1'b1) begin
        n_err++; $display("FAIL shift_oe k=%0d: got %b expected 1", k, bus.hub_oe_n);
      end
    end
    tick();
    n_cmp++;
    if ({bus.hub_st, bus.hub_oe_n, bus.row_addr} !== 7'b11_00000) begin
      n_err++; $display("FAIL latch: got st/oe/row %b expected 1100000",
                        {bus.hub_st, bus.hub_oe_n, bus.row_addr});
    end
    tick();
    n_cmp++;
    if ({bus.hub_st, bus.hub_oe_n} !== 2'b01) begin
      n_err++; $display("FAIL guard: got st/oe %b expected 01", {bus.hub_st, bus.hub_oe_n});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.hub_oe_n !== 1'b0) begin
        n_err++; $display("FAIL display_oe cyc=%0d: got %b expected 0", i, bus.hub_oe_n);
      end
    end
    tick();
    n_cmp++;
    if ({bus.hub_oe_n, bus.plane, bus.frame_start, bus.ram_rd} !== 5'b1_01_0_1) begin
      n_err++; $display("FAIL next_plane_shift: got oe/plane/fs/rd %b expected 10101",
                        {bus.hub_oe_n, bus.plane, bus.frame_start, bus.ram_rd});
    end
  endtask

  task automatic test_full_frame();
    int runs[$];
    int lrows[$];
    int dplanes[$];
    int fs[$];
    int cur;
    logic prev_oe;
    int exp_runs[6]  = '{2, 4, 8, 2, 4, 8};
    int exp_rows[6]  = '{0, 0, 0, 1, 1, 1};
    int exp_plane[6] = '{0, 1, 2, 0, 1, 2};
    cur = 0;
    prev_oe = 1'b1;
    do_reset();
    bus.enable = 1'b1;
    tick();
    for (int c = 0; c < 200; c++) begin
      if (c > 0) tick();
      if (bus.frame_start) fs.push_back(c);
      if (bus.hub_st) lrows.push_back(int'(bus.row_addr));
      if (!bus.hub_oe_n) begin
        if (prev_oe) dplanes.push_back(int'(bus.plane));
        cur++;
      end else if (!prev_oe) begin
        runs.push_back(cur);
        cur = 0;
      end
      prev_oe = bus.hub_oe_n;
    end
    n_cmp++;
    if (runs.size() < 6 || lrows.size() < 6 || dplanes.size() < 6) begin
      n_err++; $display("FAIL frame_event_count: got runs=%0d latches=%0d expected >=6",
                        runs.size(), lrows.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < runs.size()) begin
        n_cmp++;
        if (runs[i] != exp_runs[i]) begin
          n_err++; $display("FAIL oe_run[%0d]: got %0d expected %0d", i, runs[i], exp_runs[i]);
        end
      end
      if (i < lrows.size()) begin
        n_cmp++;
        if (lrows[i] != exp_rows[i]) begin
          n_err++; $display("FAIL latch_row[%0d]: got %0d expected %0d", i, lrows[i], exp_rows[i]);
        end
      end
      if (i < dplanes.size()) begin
        n_cmp++;
        if (dplanes[i] != exp_plane[i]) begin
          n_err++; $display("FAIL disp_plane[%0d]: got %0d expected %0d", i, dplanes[i], exp_plane[i]);
        end
      end
    end
    n_cmp++;
    if (fs.size() != 3) begin
      n_err++; $display("FAIL frame_start_count: got %0d expected 3", fs.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < fs.size()) begin
        n_cmp++;
        if (fs[i] != 94 * i) begin
          n_err++; $display("FAIL frame_start_cycle[%0d]: got %0d expected %0d", i, fs[i], 94 * i);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    int oe_cnt;
    bit stopped;
    found = 1'b0;
    oe_cnt = 0;
    stopped = 1'b0;
    do_reset();
    bus.enable = 1'b1;
    tick();
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (bus.ram_rd && bus.plane == 2'd1 && bus.ram_addr[2]) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL drop_find_row1_plane1: got not found expected found");
    end
    bus.enable = 1'b0;
    for (int c = 0; c < 100 && !stopped; c++) begin
      tick();
      if (!bus.hub_oe_n) oe_cnt++;
      if (!bus.busy) stopped = 1'b1;
    end
    n_cmp++;
    if (!stopped) begin
      n_err++; $display("FAIL drop_reach_idle: got busy still 1 expected 0 within 100 cycles");
    end
    n_cmp++;
    if (oe_cnt != 4) begin
      n_err++; $display("FAIL drop_oe_cycles: got %0d expected 4", oe_cnt);
    end
    n_cmp++;
    if (bus.hub_oe_n !== 1'b1) begin
      n_err++; $display("FAIL drop_idle_oe: got %b expected 1", bus.hub_oe_n);
    end
    tick();
    tick();
    n_cmp++;
    if ({bus.busy, bus.hub_oe_n, bus.ram_rd} !== 3'b010) begin
      n_err++; $display("FAIL drop_stays_idle: got busy/oe/rd %b expected 010",
                        {bus.busy, bus.hub_oe_n, bus.ram_rd});
    end
    bus.enable = 1'b1;
    tick();
    n_cmp++;
    if ({bus.frame_start, bus.plane, bus.ram_addr} !== 7'b1_00_0000) begin
      n_err++; $display("FAIL restart: got fs/plane/addr %b expected 1000000",
                        {bus.frame_start, bus.plane, bus.ram_addr});
    end
  endtask

`ifdef DOUBLE_BUFFER_EN
  task automatic test_swap();
    int c;
    int early;
    bit hit;
    do_reset();
    bus.enable = 1'b1;
    tick();
    early = 0;
    hit = 1'b0;
    c = 0;
    while (c < 200 && !hit) begin
      tick();
      c++;
      if (c == 20) bus.swap_req = 1'b1;
      if (bus.frame_start) hit = 1'b1;
      else if (bus.swap_ack || bus.bank) early++;
    end
    n_cmp++;
    if (c != 94 || early != 0) begin
      n_err++; $display("FAIL swap_wait: got frame at %0d early=%0d expected 94 early=0", c, early);
    end
    n_cmp++;
    if ({bus.bank, bus.swap_ack, bus.ram_addr[3]} !== 3'b111) begin
      n_err++; $display("FAIL swap_0to1: got bank/ack/msb %b expected 111",
                        {bus.bank, bus.swap_ack, bus.ram_addr[3]});
    end
    tick();
    n_cmp++;
    if ({bus.bank, bus.swap_ack} !== 2'b10) begin
      n_err++; $display("FAIL swap_ack_pulse: got bank/ack %b expected 10", {bus.bank, bus.swap_ack});
    end
    hit = 1'b0;
    early = 0;
    c = 1;
    while (c < 200 && !hit) begin
      tick();
      c++;
      if (bus.frame_start) hit = 1'b1;
      else if (bus.swap_ack || !bus.bank) early++;
    end
    n_cmp++;
    if (c != 94 || early != 0) begin
      n_err++; $display("FAIL swap_wait2: got frame at %0d early=%0d expected 94 early=0", c, early);
    end
    n_cmp++;
    if ({bus.bank, bus.swap_ack, bus.ram_addr[3]} !== 3'b010) begin
      n_err++; $display("FAIL swap_1to0: got bank/ack/msb %b expected 010",
                        {bus.bank, bus.swap_ack, bus.ram_addr[3]});
    end
    bus.swap_req = 1'b0;
  endtask
`else
  task automatic test_no_swap();
    int frames;
    int bad;
    frames = 0;
    bad = 0;
    do_reset();
    bus.swap_req = 1'b1;
    bus.enable = 1'b1;
    tick();
    for (int c = 0; c < 290; c++) begin
      if (c > 0) tick();
      if (bus.frame_start) frames++;
      if (bus.bank || bus.swap_ack || bus.ram_addr[3]) bad++;
    end
    n_cmp++;
    if (frames != 4) begin
      n_err++; $display("FAIL noswap_frames: got %0d expected 4", frames);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL noswap_bank: got %0d bad cycles expected 0", bad);
    end
    bus.swap_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int frames;
    bit in_disp;
    frames = 0;
    in_disp = 1'b0;
    do_reset();
    bus.swap_req = 1'b1;
    bus.enable = 1'b1;
    for (int c = 0; c < 300 && frames < 2; c++) begin
      tick();
      if (bus.frame_start) frames++;
    end
    for (int c = 0; c < 50 && !in_disp; c++) begin
      tick();
      if (!bus.hub_oe_n) in_disp = 1'b1;
    end
    n_cmp++;
    if (!in_disp || frames != 2) begin
      n_err++; $display("FAIL midreset_setup: got frames=%0d disp=%0b expected 2/1", frames, in_disp);
    end
    resetn = 1'b0;
    tick();
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_err++; $display("FAIL midreset_outputs: got %h expected %h", outs(), RST_VEC);
    end
    bus.enable = 1'b0;
    bus.swap_req = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.swap_req = 1'b0;
    test_reset();
    test_first_row();
    test_full_frame();
    test_enable_drop();
`ifdef DOUBLE_BUFFER_EN
    test_swap();
`else
    test_no_swap();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
